exec_controller: RTL and testbench

Parametrised execute-stage sequencer for the single-issue core. It sits between the decoder and the register file, LSU, mul/div unit and fetch. It decides per instruction whether the register file may be written, when the instruction retires, when fetch is redirected, and when a trap is taken. It supports wait-state LSU and mul/div operations, an LSU timeout/error trap, mret, and optional external interrupts.

---
 rtl/exec_controller.sv | 152 +++++++++++++++
 tb/tb_exec_controller.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/exec_controller.sv
// exec_controller: execute-stage sequencer gating regfile writes, retire, redirects and traps.
// Define CTRL_IRQ_EN to let irq_i take a trap at top IDLE priority.
module exec_controller #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned EXC_BASE    = 0,
    parameter int unsigned CNT_WIDTH   = 4,
    parameter int unsigned LSU_TIMEOUT = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inst_valid_i,
    input  logic                  jump_inst_i,
    input  logic                  branch_inst_i,
    input  logic                  mret_inst_i,
    input  logic                  ecall_inst_i,
    input  logic                  ebreak_inst_i,
    input  logic                  illegal_inst_i,
    input  logic                  lsu_en_i,
    input  logic                  lsu_done_i,
    input  logic                  lsu_err_i,
    input  logic                  muldiv_en_i,
    input  logic                  muldiv_done_i,
    input  logic                  comp_result_i,
    input  logic                  irq_i,
    output logic [CNT_WIDTH-1:0]  cycle_counter_o,
    output logic                  deassert_wen_n_o,
    output logic                  retire_o,
    output logic                  stall_o,
    output logic                  target_valid_o,
    output logic                  save_epc_o,
    output logic [ADDR_WIDTH-1:0] exc_pc_o,
    output logic [4:0]            exc_cause_o,
    output logic                  mret_o
);
    typedef enum logic [1:0] {IDLE, LSU_WAIT, MD_WAIT, REDIRECT} state_t;
`ifdef CTRL_IRQ_EN
    localparam logic IRQ_EN = 1'b1;
`else
    localparam logic IRQ_EN = 1'b0;
`endif
    localparam logic [ADDR_WIDTH-1:0] PC_ECALL = ADDR_WIDTH'(EXC_BASE + 4);
    localparam logic [ADDR_WIDTH-1:0] PC_ILL   = ADDR_WIDTH'(EXC_BASE + 8);
    localparam logic [ADDR_WIDTH-1:0] PC_EBRK  = ADDR_WIDTH'(EXC_BASE + 12);
    localparam logic [ADDR_WIDTH-1:0] PC_LSU   = ADDR_WIDTH'(EXC_BASE + 16);
    localparam logic [ADDR_WIDTH-1:0] PC_IRQ   = ADDR_WIDTH'(EXC_BASE + 20);
    localparam logic [CNT_WIDTH-1:0]  TMO      = CNT_WIDTH'(LSU_TIMEOUT - 1);

    state_t                  cs, ns;
    logic [CNT_WIDTH-1:0]    cnt;
    logic                    wen, ret, tv, trap, mret;
    logic [ADDR_WIDTH-1:0]   trap_pc;
    logic [4:0]              trap_cause;

    // Gating on rst as well keeps every output at 0 while reset is held.
    always_comb begin
        ns = cs;
        wen = 1'b0;
        ret = 1'b0;
        tv = 1'b0;
        trap = 1'b0;
        mret = 1'b0;
        trap_pc = '0;
        trap_cause = '0;
        if (inst_valid_i && !rst) begin
            case (cs)
                IDLE: begin
                    if (irq_i && IRQ_EN) begin
                        trap = 1'b1;
                        trap_pc = PC_IRQ;
                        trap_cause = 5'h1b;
                    end else if (illegal_inst_i) begin
                        trap = 1'b1;
                        trap_pc = PC_ILL;
                        trap_cause = 5'd2;
                    end else if (ecall_inst_i) begin
                        trap = 1'b1;
                        trap_pc = PC_ECALL;
                        trap_cause = 5'd11;
                    end else if (ebreak_inst_i) begin
                        trap = 1'b1;
                        trap_pc = PC_EBRK;
                        trap_cause = 5'd3;
                    end else if (lsu_en_i) begin
                        ns = LSU_WAIT;
                    end else if (muldiv_en_i) begin
                        ns = MD_WAIT;
                    end else if (jump_inst_i) begin
                        wen = 1'b1;
                        ns = REDIRECT;
                    end else if (branch_inst_i) begin
                        ret = !comp_result_i;
                        ns = comp_result_i ? REDIRECT : IDLE;
                    end else if (mret_inst_i) begin
                        mret = 1'b1;
                        tv = 1'b1;
                        ret = 1'b1;
                    end else begin
                        wen = 1'b1;
                        ret = 1'b1;
                    end
                end
                LSU_WAIT: begin
                    if (lsu_done_i && !lsu_err_i) begin
                        wen = 1'b1;
                        ret = 1'b1;
                        ns = IDLE;
                    end else if (lsu_done_i || cnt == TMO) begin
                        trap = 1'b1;
                        trap_pc = PC_LSU;
                        trap_cause = 5'd5;
                        ns = IDLE;
                    end
                end
                MD_WAIT: begin
                    if (muldiv_done_i) begin
                        wen = 1'b1;
                        ret = 1'b1;
                        ns = IDLE;
                    end
                end
                default: begin
                    tv = 1'b1;
                    ret = 1'b1;
                    ns = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs <= IDLE;
            cnt <= '0;
        end else begin
            cs <= ns;
            if (ns == IDLE)
                cnt <= '0;
            else if (inst_valid_i && cnt != '1)
                cnt <= cnt + 1'b1;
        end
    end

    assign cycle_counter_o  = cnt;
    assign deassert_wen_n_o = wen;
    assign retire_o         = ret;
    assign stall_o          = inst_valid_i && !rst && ns != IDLE;
    assign target_valid_o   = tv | trap;
    assign save_epc_o       = trap;
    assign exc_pc_o         = trap_pc;
    assign exc_cause_o      = trap_cause;
    assign mret_o           = mret;
endmodule

// File: tb/tb_exec_controller.sv
// tb_exec_controller: random instruction stream against a transaction-level model, checked via a scoreboard.
module tb_exec_controller;
    localparam int unsigned BASE = 32'h100;
    localparam int TMO = 8;
`ifdef CTRL_IRQ_EN
    localparam bit IRQ = 1'b1;
`else
    localparam bit IRQ = 1'b0;
`endif

    typedef struct packed {
        logic irq, ill, ec, eb, lsu, md, jmp, br, mr, comp;
    } dec_t;
    typedef struct packed {
        logic wen, ret, stall, tv, save, mret;
        logic [31:0] pc;
        logic [4:0] cause;
        logic [3:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic inst_valid_i = 1'b0;
    logic jump_inst_i = 1'b0, branch_inst_i = 1'b0, mret_inst_i = 1'b0;
    logic ecall_inst_i = 1'b0, ebreak_inst_i = 1'b0, illegal_inst_i = 1'b0;
    logic lsu_en_i = 1'b0, lsu_done_i = 1'b0, lsu_err_i = 1'b0;
    logic muldiv_en_i = 1'b0, muldiv_done_i = 1'b0, comp_result_i = 1'b0, irq_i = 1'b0;
    logic [3:0] cycle_counter_o;
    logic deassert_wen_n_o, retire_o, stall_o, target_valid_o, save_epc_o, mret_o;
    logic [31:0] exc_pc_o;
    logic [4:0] exc_cause_o;

    exp_t exp_q[$];
    int total = 0;
    int bad = 0;

    exec_controller #(.ADDR_WIDTH(32), .EXC_BASE(BASE), .CNT_WIDTH(4), .LSU_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .inst_valid_i(inst_valid_i),
        .jump_inst_i(jump_inst_i), .branch_inst_i(branch_inst_i), .mret_inst_i(mret_inst_i),
        .ecall_inst_i(ecall_inst_i), .ebreak_inst_i(ebreak_inst_i), .illegal_inst_i(illegal_inst_i),
        .lsu_en_i(lsu_en_i), .lsu_done_i(lsu_done_i), .lsu_err_i(lsu_err_i),
        .muldiv_en_i(muldiv_en_i), .muldiv_done_i(muldiv_done_i), .comp_result_i(comp_result_i),
        .irq_i(irq_i), .cycle_counter_o(cycle_counter_o), .deassert_wen_n_o(deassert_wen_n_o),
        .retire_o(retire_o), .stall_o(stall_o), .target_valid_o(target_valid_o),
        .save_epc_o(save_epc_o), .exc_pc_o(exc_pc_o), .exc_cause_o(exc_cause_o), .mret_o(mret_o)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic wen, ret, stall, tv, save, mr, input logic [31:0] pc,
                                input logic [4:0] cause, input int cnt);
        mk = '{wen, ret, stall, tv, save, mr, pc, cause, 4'(cnt)};
    endfunction

    function automatic exp_t tr(input int off, input logic [4:0] cause, input int cnt);
        tr = mk(0, 0, 0, 1, 1, 0, BASE + off, cause, cnt);
    endfunction

    function automatic logic rn();
        rn = 1'($urandom_range(0, 1));
    endfunction

    task automatic cyc(input logic r, v, input dec_t d, input logic ld, le, mdn, input exp_t e);
        @(posedge clk);
        #1;
        rst = r;
        inst_valid_i = v;
        {irq_i, illegal_inst_i, ecall_inst_i, ebreak_inst_i, lsu_en_i, muldiv_en_i,
         jump_inst_i, branch_inst_i, mret_inst_i, comp_result_i} = d;
        lsu_done_i = ld;
        lsu_err_i = le;
        muldiv_done_i = mdn;
        exp_q.push_back(e);
    endtask

    // Stalled-cycle gap: inst_valid low, all outputs 0, counter frozen.
    task automatic gap(input dec_t d, input int cnt);
        cyc(0, 0, d, rn(), rn(), rn(), mk(0, 0, 0, 0, 0, 0, 0, 0, cnt));
    endtask

    // One instruction from decode to retirement, expectations from the outcome rules.
    task automatic run_inst(input dec_t d, input int dly, input logic err);
        dec_t dn;
        int v, k;
        bit fin;
        if (IRQ && d.irq) cyc(0, 1, d, rn(), rn(), rn(), tr(20, 5'h1b, 0));
        else if (d.ill) cyc(0, 1, d, rn(), rn(), rn(), tr(8, 5'd2, 0));
        else if (d.ec) cyc(0, 1, d, rn(), rn(), rn(), tr(4, 5'd11, 0));
        else if (d.eb) cyc(0, 1, d, rn(), rn(), rn(), tr(12, 5'd3, 0));
        else if (d.lsu || d.md) begin
            cyc(0, 1, d, rn(), rn(), rn(), mk(0, 0, 1, 0, 0, 0, 0, 0, 0));
            v = 1;
            k = 0;
            fin = 0;
            while (!fin) begin
                dn = d;
                dn.irq = rn();
                if ($urandom_range(0, 7) == 0) gap(dn, v);
                k++;
                if (d.lsu) begin
                    if (k == dly) begin
                        cyc(0, 1, dn, 1, err, rn(), err ? tr(16, 5'd5, v) : mk(1, 1, 0, 0, 0, 0, 0, 0, v));
                        fin = 1;
                    end else if (v == TMO - 1) begin
                        cyc(0, 1, dn, 0, rn(), rn(), tr(16, 5'd5, v));
                        fin = 1;
                    end else cyc(0, 1, dn, 0, rn(), rn(), mk(0, 0, 1, 0, 0, 0, 0, 0, v));
                end else begin
                    if (k == dly) begin
                        cyc(0, 1, dn, rn(), rn(), 1, mk(1, 1, 0, 0, 0, 0, 0, 0, v));
                        fin = 1;
                    end else cyc(0, 1, dn, rn(), rn(), 0, mk(0, 0, 1, 0, 0, 0, 0, 0, v));
                end
                v = (v < 15) ? v + 1 : 15;
            end
        end else if (d.jmp || (d.br && d.comp)) begin
            cyc(0, 1, d, rn(), rn(), rn(), mk(d.jmp, 0, 1, 0, 0, 0, 0, 0, 0));
            cyc(0, 1, d, rn(), rn(), rn(), mk(0, 1, 0, 1, 0, 0, 0, 0, 1));
        end else if (d.br) cyc(0, 1, d, rn(), rn(), rn(), mk(0, 1, 0, 0, 0, 0, 0, 0, 0));
        else if (d.mr) cyc(0, 1, d, rn(), rn(), rn(), mk(0, 1, 0, 1, 0, 1, 0, 0, 0));
        else cyc(0, 1, d, rn(), rn(), rn(), mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e, a;
            e = exp_q.pop_front();
            a = '{deassert_wen_n_o, retire_o, stall_o, target_valid_o, save_epc_o, mret_o,
                  exc_pc_o, exc_cause_o, cycle_counter_o};
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL outputs @%0t got wen=%b ret=%b stall=%b tv=%b save=%b mret=%b pc=%h cause=%h cnt=%0d want wen=%b ret=%b stall=%b tv=%b save=%b mret=%b pc=%h cause=%h cnt=%0d",
                         $time, a.wen, a.ret, a.stall, a.tv, a.save, a.mret, a.pc, a.cause, a.cnt,
                         e.wen, e.ret, e.stall, e.tv, e.save, e.mret, e.pc, e.cause, e.cnt);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        dec_t d;
        exp_t zero;
        zero = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        d = '0;
        cyc(1, 1, d, 0, 0, 0, zero);
        d.lsu = 1;
        cyc(1, 1, d, 1, 0, 1, zero);
        d = '0;
        run_inst(d, 0, 0);
        d.lsu = 1;
        run_inst(d, 3, 0);
        run_inst(d, 0, 0);
        run_inst(d, 2, 1);
        d = '0; d.br = 1; d.comp = 1;
        run_inst(d, 0, 0);
        d.comp = 0;
        run_inst(d, 0, 0);
        d = '0; d.ec = 1; d.ill = 1;
        run_inst(d, 0, 0);
        d = '0; d.irq = 1; d.lsu = 1;
        run_inst(d, 2, 0);
        d = '0; d.md = 1;
        run_inst(d, 18, 0);
        d = '0; d.mr = 1;
        run_inst(d, 0, 0);
        d = '0; d.jmp = 1;
        run_inst(d, 0, 0);
        d = '0; d.eb = 1;
        run_inst(d, 0, 0);
        // Reset in the middle of an LSU wait must abort without write or retire.
        d = '0; d.lsu = 1;
        cyc(0, 1, d, 0, 0, 0, mk(0, 0, 1, 0, 0, 0, 0, 0, 0));
        cyc(0, 1, d, 0, 0, 0, mk(0, 0, 1, 0, 0, 0, 0, 0, 1));
        cyc(0, 1, d, 0, 0, 0, mk(0, 0, 1, 0, 0, 0, 0, 0, 2));
        cyc(1, 1, d, 1, 0, 1, zero);
        d = '0;
        cyc(0, 1, d, 1, 0, 1, mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 300; i++) begin
            d = dec_t'($urandom) & dec_t'($urandom) & dec_t'($urandom);
            d.comp = rn();
            repeat ($urandom_range(0, 2)) gap(dec_t'($urandom), 0);
            run_inst(d, d.lsu ? $urandom_range(1, 9) : $urandom_range(1, 20), $urandom_range(0, 3) == 0);
        end
        repeat (2) @(posedge clk);
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
